// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver: FSM states, legal prescale values, parity encodings.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int unsigned PRESC_8  = 8;
    localparam int unsigned PRESC_16 = 16;
    localparam int unsigned PRESC_32 = 32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority voter around the bit centre.
module uart_rx_sampler #(
    parameter int unsigned PRESC_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    input  logic [PRESC_WIDTH-1:0] prescale,
    input  logic                   cnt_en,
    input  logic                   cnt_clr,
    output logic                   bit_done_c,
    output logic                   sample_valid_c,
    output logic                   sampled_bit_c
);

    logic [PRESC_WIDTH-1:0] edge_cnt;
    logic [PRESC_WIDTH-1:0] half;
    logic [PRESC_WIDTH-1:0] last;
    logic                   s_early;
    logic                   s_mid;

    assign half = prescale >> 1;
    assign last = prescale - PRESC_WIDTH'(1);

    // Edge counter wraps at P-1; cleared whenever the frame ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
            s_early  <= 1'b1;
            s_mid    <= 1'b1;
        end else begin
            if (cnt_clr) begin
                edge_cnt <= '0;
            end else if (cnt_en) begin
                edge_cnt <= bit_done_c ? '0 : edge_cnt + PRESC_WIDTH'(1);
            end
            if (cnt_en && (edge_cnt == half - PRESC_WIDTH'(1))) begin
                s_early <= rx;
            end
            if (cnt_en && (edge_cnt == half)) begin
                s_mid <= rx;
            end
        end
    end

    assign bit_done_c     = cnt_en && (edge_cnt == last);
    assign sample_valid_c = cnt_en && (edge_cnt == half + PRESC_WIDTH'(1));
    // Third sample is the live line, so the vote resolves at edge P/2+1
    assign sampled_bit_c  = (s_early & s_mid) | (s_early & rx) | (s_mid & rx);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop FSM, shift register and error strobes.
// Define UART_RX_SYNC_EN to insert a 2-flop synchroniser on RX_IN_UART.
module uart_rx #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned PRESC_WIDTH = 6
) (
    input  logic                   CLK_UART,
    input  logic                   RST_UART,
    input  logic                   RX_IN_UART,
    input  logic [PRESC_WIDTH-1:0] PRESCALE_UART,
    input  logic                   PAR_EN_UART,
    input  logic                   PAR_TYPE_UART,
    output logic [DATA_WIDTH-1:0]  P_DATA_UART,
    output logic                   DATA_VALID_UART,
    output logic                   PAR_ERR_UART,
    output logic                   STP_ERR_UART
);

    import uart_pkg::*;

    localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_t              state;
    rx_state_t              state_nxt;
    logic                   rx;
    logic [PRESC_WIDTH-1:0] presc_q;
    logic [PRESC_WIDTH-1:0] presc_eff;
    logic                   par_en_q;
    logic                   par_type_q;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [DATA_WIDTH-1:0]  shift_reg;
    logic                   par_flag;
    logic                   par_exp;
    logic                   cnt_en;
    logic                   cnt_clr_c;
    logic                   bit_done_c;
    logic                   sample_valid_c;
    logic                   sampled_bit_c;
    logic                   frame_start_c;
    logic                   data_valid_c;
    logic                   par_err_c;
    logic                   stp_err_c;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    // Idle-high synchroniser so reset never looks like a start bit
    always_ff @(posedge CLK_UART or posedge RST_UART) begin
        if (RST_UART) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RX_IN_UART};
        end
    end

    assign rx = sync_q[1];
`else
    assign rx = RX_IN_UART;
`endif

    // Live prescale drives the start cycle, before it is latched
    assign presc_eff = (state == IDLE) ? PRESCALE_UART : presc_q;
    assign cnt_en    = (state != IDLE) || !rx;
    assign cnt_clr_c = (state != IDLE) && (state_nxt == IDLE);
    assign par_exp   = (par_type_q == PAR_ODD) ? ~^shift_reg : ^shift_reg;

    uart_rx_sampler #(
        .PRESC_WIDTH (PRESC_WIDTH)
    ) u_sampler (
        .clk            (CLK_UART),
        .rst            (RST_UART),
        .rx             (rx),
        .prescale       (presc_eff),
        .cnt_en         (cnt_en),
        .cnt_clr        (cnt_clr_c),
        .bit_done_c     (bit_done_c),
        .sample_valid_c (sample_valid_c),
        .sampled_bit_c  (sampled_bit_c)
    );

    always_ff @(posedge CLK_UART or posedge RST_UART) begin
        if (RST_UART) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        frame_start_c = 1'b0;
        data_valid_c  = 1'b0;
        par_err_c     = 1'b0;
        stp_err_c     = 1'b0;
        case (state)
            IDLE: begin
                if (!rx) begin
                    state_nxt     = START;
                    frame_start_c = 1'b1;
                end
            end
            START: begin
                if (sample_valid_c && sampled_bit_c) begin
                    state_nxt = IDLE;
                end else if (bit_done_c) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_done_c && (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1))) begin
                    state_nxt = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_done_c) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // Leave mid-stop-bit so a following start edge is not missed
                if (sample_valid_c) begin
                    state_nxt    = IDLE;
                    stp_err_c    = !sampled_bit_c;
                    par_err_c    = par_flag;
                    data_valid_c = sampled_bit_c && !par_flag;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame configuration, bit counter, shift register and parity flag
    always_ff @(posedge CLK_UART or posedge RST_UART) begin
        if (RST_UART) begin
            presc_q    <= PRESC_WIDTH'(PRESC_8);
            par_en_q   <= 1'b0;
            par_type_q <= PAR_EVEN;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_flag   <= 1'b0;
        end else begin
            if (frame_start_c) begin
                presc_q    <= PRESCALE_UART;
                par_en_q   <= PAR_EN_UART;
                par_type_q <= PAR_TYPE_UART;
                bit_cnt    <= '0;
                par_flag   <= 1'b0;
            end
            if ((state == DATA) && sample_valid_c) begin
                shift_reg <= {sampled_bit_c, shift_reg[DATA_WIDTH-1:1]};
            end
            if ((state == DATA) && bit_done_c) begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
            if ((state == PARITY) && sample_valid_c) begin
                par_flag <= sampled_bit_c ^ par_exp;
            end
        end
    end

    always_ff @(posedge CLK_UART or posedge RST_UART) begin
        if (RST_UART) begin
            P_DATA_UART     <= '0;
            DATA_VALID_UART <= 1'b0;
            PAR_ERR_UART    <= 1'b0;
            STP_ERR_UART    <= 1'b0;
        end else begin
            DATA_VALID_UART <= data_valid_c;
            PAR_ERR_UART    <= par_err_c;
            STP_ERR_UART    <= stp_err_c;
            if (data_valid_c) begin
                P_DATA_UART <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framing, parity, stop errors, glitches, back-to-back and reset abort.
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_line;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_type;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int par_cnt = 0;
    int stp_cnt = 0;
    int valid_cyc = 0;
    int start_cyc = 0;

    uart_rx dut (
        .CLK_UART        (clk),
        .RST_UART        (rst),
        .RX_IN_UART      (rx_line),
        .PRESCALE_UART   (prescale),
        .PAR_EN_UART     (par_en),
        .PAR_TYPE_UART   (par_type),
        .P_DATA_UART     (p_data),
        .DATA_VALID_UART (data_valid),
        .PAR_ERR_UART    (par_err),
        .STP_ERR_UART    (stp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count every cycle a strobe is high, so a stuck strobe shows up as an extra count
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            valid_cnt <= valid_cnt + 1;
            valid_cyc <= cyc;
        end
        if (par_err === 1'b1) par_cnt <= par_cnt + 1;
        if (stp_err === 1'b1) stp_cnt <= stp_cnt + 1;
    end

    task automatic hold_line(input logic b, input int n);
        rx_line = b;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame starting at the current negedge; spike_bit >= 0 flips that data bit for one cycle at its centre
    task automatic send_frame(input logic [7:0] d, input int p, input logic pe, input logic pbit,
                              input logic stopb, input int spike_bit);
        logic [7:0] dv;
        dv = d;
        start_cyc = cyc;
        hold_line(1'b0, p);
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < p; c++) begin
                rx_line = (i == spike_bit && c == p / 2) ? ~dv[i] : dv[i];
                @(negedge clk);
            end
        end
        if (pe) hold_line(pbit, p);
        hold_line(stopb, p);
        rx_line = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx_line = 1'b1;
        prescale = 6'd8;
        par_en = 1'b0;
        par_type = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({p_data, data_valid, par_err, stp_err} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=%h", {p_data, data_valid, par_err, stp_err}, 11'd0);
        end
        rst = 1'b0;
        hold_line(1'b1, 4);
        checks++;
        if (valid_cnt + par_cnt + stp_cnt !== 0) begin
            errors++;
            $display("FAIL reset_idle_strobes got=%0d exp=0", valid_cnt + par_cnt + stp_cnt);
        end
    endtask

    task automatic test_p8_basic;
        int v0, pe0, se0;
        v0 = valid_cnt; pe0 = par_cnt; se0 = stp_cnt;
        prescale = 6'd8; par_en = 1'b0;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1);
        hold_line(1'b1, 16);
        checks++;
        if (valid_cnt - v0 !== 1) begin
            errors++; $display("FAIL p8_valid_count got=%0d exp=1", valid_cnt - v0);
        end
        checks++;
        if (p_data !== 8'hA5) begin
            errors++; $display("FAIL p8_data got=%h exp=a5", p_data);
        end
        checks++;
        if ((par_cnt - pe0) + (stp_cnt - se0) !== 0) begin
            errors++; $display("FAIL p8_no_errors got=%0d exp=0", (par_cnt - pe0) + (stp_cnt - se0));
        end
        checks++;
        if (valid_cyc - start_cyc !== 78 + SYNC_LAT) begin
            errors++; $display("FAIL p8_latency got=%0d exp=%0d", valid_cyc - start_cyc, 78 + SYNC_LAT);
        end
    endtask

    task automatic test_even_parity;
        int v0, pe0, se0;
        prescale = 6'd16; par_en = 1'b1; par_type = 1'b0;
        v0 = valid_cnt; pe0 = par_cnt; se0 = stp_cnt;
        send_frame(8'hE6, 16, 1'b1, 1'b1, 1'b1, -1);
        hold_line(1'b1, 32);
        checks++;
        if (valid_cnt - v0 !== 1 || p_data !== 8'hE6) begin
            errors++; $display("FAIL even_good got=%0d/%h exp=1/e6", valid_cnt - v0, p_data);
        end
        checks++;
        if (valid_cyc - start_cyc !== 170 + SYNC_LAT) begin
            errors++; $display("FAIL even_latency got=%0d exp=%0d", valid_cyc - start_cyc, 170 + SYNC_LAT);
        end
        v0 = valid_cnt;
        send_frame(8'hE6, 16, 1'b1, 1'b0, 1'b1, -1);
        hold_line(1'b1, 32);
        checks++;
        if (par_cnt - pe0 !== 1 || stp_cnt - se0 !== 0 || valid_cnt - v0 !== 0) begin
            errors++;
            $display("FAIL even_bad_parity got=par%0d/stp%0d/val%0d exp=1/0/0",
                     par_cnt - pe0, stp_cnt - se0, valid_cnt - v0);
        end
        checks++;
        if (p_data !== 8'hE6) begin
            errors++; $display("FAIL even_bad_hold got=%h exp=e6", p_data);
        end
    endtask

    task automatic test_stop_err;
        int v0, pe0, se0;
        prescale = 6'd32; par_en = 1'b1; par_type = 1'b1;
        v0 = valid_cnt; pe0 = par_cnt; se0 = stp_cnt;
        send_frame(8'hD2, 32, 1'b1, 1'b1, 1'b0, -1);
        hold_line(1'b1, 96);
        checks++;
        if (stp_cnt - se0 !== 1 || par_cnt - pe0 !== 0 || valid_cnt - v0 !== 0) begin
            errors++;
            $display("FAIL stop_err got=stp%0d/par%0d/val%0d exp=1/0/0",
                     stp_cnt - se0, par_cnt - pe0, valid_cnt - v0);
        end
        checks++;
        if (p_data !== 8'hE6) begin
            errors++; $display("FAIL stop_err_hold got=%h exp=e6", p_data);
        end
        send_frame(8'h3C, 32, 1'b1, 1'b1, 1'b1, -1);
        hold_line(1'b1, 64);
        checks++;
        if (valid_cnt - v0 !== 1 || p_data !== 8'h3C) begin
            errors++; $display("FAIL odd_good got=%0d/%h exp=1/3c", valid_cnt - v0, p_data);
        end
    endtask

    task automatic test_glitch;
        int v0, pe0, se0;
        prescale = 6'd8; par_en = 1'b0;
        v0 = valid_cnt; pe0 = par_cnt; se0 = stp_cnt;
        hold_line(1'b0, 3);
        hold_line(1'b1, 20);
        checks++;
        if ((valid_cnt - v0) + (par_cnt - pe0) + (stp_cnt - se0) !== 0) begin
            errors++; $display("FAIL glitch_strobes got=%0d exp=0",
                               (valid_cnt - v0) + (par_cnt - pe0) + (stp_cnt - se0));
        end
        checks++;
        if (p_data !== 8'h3C) begin
            errors++; $display("FAIL glitch_hold got=%h exp=3c", p_data);
        end
        send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1, 3);
        hold_line(1'b1, 16);
        checks++;
        if (valid_cnt - v0 !== 1 || p_data !== 8'h96) begin
            errors++; $display("FAIL spike_data got=%0d/%h exp=1/96", valid_cnt - v0, p_data);
        end
    endtask

    task automatic test_back_to_back;
        int v0;
        logic [7:0] bytes [3];
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
        prescale = 6'd16; par_en = 1'b0;
        v0 = valid_cnt;
        for (int k = 0; k < 3; k++) begin
            send_frame(bytes[k], 16, 1'b0, 1'b0, 1'b1, -1);
            checks++;
            if (p_data !== bytes[k]) begin
                errors++; $display("FAIL b2b_data%0d got=%h exp=%h", k, p_data, bytes[k]);
            end
        end
        hold_line(1'b1, 32);
        checks++;
        if (valid_cnt - v0 !== 3) begin
            errors++; $display("FAIL b2b_count got=%0d exp=3", valid_cnt - v0);
        end
    endtask

    task automatic test_reset_mid;
        int v0, pe0, se0;
        prescale = 6'd8; par_en = 1'b0;
        v0 = valid_cnt; pe0 = par_cnt; se0 = stp_cnt;
        hold_line(1'b0, 8);
        hold_line(1'b1, 8);
        hold_line(1'b0, 8);
        hold_line(1'b0, 4);
        rst = 1'b1;
        #1;
        checks++;
        if ({p_data, data_valid, par_err, stp_err} !== 11'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs got=%h exp=%h", {p_data, data_valid, par_err, stp_err}, 11'd0);
        end
        @(negedge clk);
        hold_line(1'b1, 4);
        rst = 1'b0;
        hold_line(1'b1, 8);
        checks++;
        if ((valid_cnt - v0) + (par_cnt - pe0) + (stp_cnt - se0) !== 0) begin
            errors++; $display("FAIL rst_mid_strobes got=%0d exp=0",
                               (valid_cnt - v0) + (par_cnt - pe0) + (stp_cnt - se0));
        end
        send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b1, -1);
        hold_line(1'b1, 16);
        checks++;
        if (valid_cnt - v0 !== 1 || p_data !== 8'h7E) begin
            errors++; $display("FAIL rst_mid_next got=%0d/%h exp=1/7e", valid_cnt - v0, p_data);
        end
        checks++;
        if (valid_cyc - start_cyc !== 78 + SYNC_LAT) begin
            errors++; $display("FAIL rst_mid_latency got=%0d exp=%0d", valid_cyc - start_cyc, 78 + SYNC_LAT);
        end
    endtask

    initial begin
        test_reset();
        test_p8_basic();
        test_even_parity();
        test_stop_err();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
